// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one memory-mapped UART transmitter between two byte requesters.
// Each byte is written to the TX register, then the control register is polled until the transmitter is idle.
module uart_tx_sched #(
    parameter logic [31:0] TX_ADDR    = 32'h40000018,
    parameter logic [31:0] CON_ADDR   = 32'h40000020,
    parameter int          BUSY_BIT   = 4,
    parameter int          SETTLE_CYC = 8,
    parameter int          TIMEOUT    = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        done,
    output logic        last_src,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic [1:0]  fsm_state
);

    localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    // The write cycle and the setting edge both count, so the flag is visible TIMEOUT cycles after wr.
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT - 2);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WRITE, SETTLE, POLL} state_t;

    state_t        state, state_next;
    logic          rr_ptr;
    logic [7:0]    tx_byte;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmo_cnt;

    logic accept, winner, poll_idle, tmo_hit;
    logic rdata_unused;

    assign fsm_state    = state;
    assign rdata_unused = ^rdata;

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        addr       = 32'h0;
        wdata      = 32'h0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        winner     = 1'b0;
        poll_idle  = 1'b0;
        tmo_hit    = ((state == SETTLE) || (state == POLL)) && (tmo_cnt >= TMO_LIMIT);

        case (state)
            IDLE: begin
                // Readies are gated by reset so they drop the moment reset asserts.
                if (reset && !done) begin
                    winner = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
                    if (req0_valid || req1_valid) begin
                        accept     = 1'b1;
                        req0_ready = !winner;
                        req1_ready = winner;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    wr         = 1'b1;
                    addr       = TX_ADDR;
                    wdata      = {24'h0, tx_byte};
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (tmo_hit) begin
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = POLL;
                end
            end
            POLL: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    rd        = 1'b1;
                    addr      = CON_ADDR;
                    poll_idle = !rdata[BUSY_BIT];
                end
                // An idle observation takes precedence over a coincident timeout.
                if (poll_idle || tmo_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            last_src    <= 1'b0;
            timeout_err <= 1'b0;
            tx_byte     <= 8'h0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= poll_idle;

            if (accept) begin
                tx_byte  <= winner ? req1_data : req0_data;
                last_src <= winner;
                rr_ptr   <= !winner;
            end

            if (state == WRITE && bus_gnt) begin
                settle_cnt <= '0;
                tmo_cnt    <= '0;
            end else if (state == SETTLE || state == POLL) begin
                if (state == SETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (tmo_hit && !poll_idle) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: requester queues, a UART busy model on rdata,
// and a negedge monitor that checks accepts, bus cycles and done pulses against a scoreboard.
module tb_uart_tx_sched;

    localparam int          TMO      = 50;
    localparam int          SETTLE   = 8;
    localparam int          BUSY_BIT = 4;
    localparam logic [31:0] TX_A     = 32'h40000018;
    localparam logic [31:0] CON_A    = 32'h40000020;
    localparam logic [31:0] BMASK    = 32'h1 << BUSY_BIT;

    logic        clk, reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_data, req1_data;
    logic        bus_req, bus_gnt, rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        done, last_src, timeout_err, err_clr;
    logic [1:0]  fsm_state;

    uart_tx_sched #(.SETTLE_CYC(SETTLE), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .last_src(last_src),
        .timeout_err(timeout_err), .err_clr(err_clr), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    logic [7:0] q0[$], q1[$];
    bit          drv_en = 0;
    int          gnt_mode = 1;      // 0 random, 1 always granted, 2 never granted
    int          p0 = 100, p1 = 100;
    bit          stuck = 0;
    int          busy_fixed = -1;
    int          busy_len = 0;
    logic [31:0] noise = 32'h0;

    // ---------------- reference model / scoreboard state ----------------
    int          cyc = 0, wr_cyc = -1000, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
    bit          inflight = 0, awaiting = 0, done_due = 0, err_prev = 0, model_last = 1;
    logic [31:0] exp_q[$];
    logic        src_q[$];
    int          accept_log[$];
    int          wr_count = 0, done_count = 0;

    // UART model: busy for busy_len cycles after each write, other bits are noise.
    assign rdata = (noise & ~BMASK) | ((stuck || ((cyc - wr_cyc) < busy_len)) ? BMASK : 32'h0);

    // ---------------- driver ----------------
    always begin
        @(posedge clk);
        #1;
        noise = $urandom;
        if (drv_en) begin
            req0_valid = (q0.size() > 0) && ($urandom_range(0, 99) < p0);
            req1_valid = (q1.size() > 0) && ($urandom_range(0, 99) < p1);
            req0_data  = (q0.size() > 0) ? q0[0] : 8'($urandom);
            req1_data  = (q1.size() > 0) ? q1[0] : 8'($urandom);
            case (gnt_mode)
                0:       bus_gnt = ($urandom_range(0, 3) != 0);
                1:       bus_gnt = 1'b1;
                default: bus_gnt = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        bit pd, any, w, busy_now;
        cyc++;
        pd = 0;
        if (!reset) begin
            inflight = 0; awaiting = 0; done_due = 0; model_last = 1; err_prev = 0;
            exp_q.delete();
            src_q.delete();
        end else begin
            busy_now = stuck || ((cyc - wr_cyc) < busy_len);

            if (timeout_err && !err_prev) begin
                err_cyc = cyc;
                chk("tmo_inflight", 32'(inflight), 32'd1);
                if (src_q.size() > 0) void'(src_q.pop_front());
                inflight = 0;
            end
            err_prev = timeout_err;

            if (req0_ready && req1_ready) chk("ready_onehot", 32'd1, 32'd0);

            if (awaiting) begin
                chk("wr_bus_req", 32'(bus_req), 32'd1);
                if (bus_gnt) begin
                    chk("wr_strobe", 32'(wr), 32'd1);
                    chk("wr_addr", addr, TX_A);
                    chk("wr_data", wdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD);
                    awaiting = 0;
                    wr_cyc = cyc;
                    wr_count++;
                    busy_len = (busy_fixed >= 0) ? busy_fixed : int'($urandom_range(0, 25));
                end else begin
                    chk("stall_wr", 32'(wr), 32'd0);
                    chk("stall_addr", addr, 32'd0);
                end
            end else if (wr) begin
                chk("spurious_wr", 32'(wr), 32'd0);
            end

            if (rd) begin
                chk("rd_when_polling", 32'(inflight && !awaiting), 32'd1);
                chk("rd_addr", addr, CON_A);
                pd = !busy_now;
            end

            if (inflight) begin
                if (req0_ready || req1_ready) chk("ready_while_busy", {req0_ready, req1_ready}, 32'd0);
            end else begin
                any = req0_valid || req1_valid;
                w   = (req0_valid && req1_valid) ? !model_last : req1_valid;
                chk("ready0", 32'(req0_ready), 32'(any && !w));
                chk("ready1", 32'(req1_ready), 32'(any && w));
                if (any) begin
                    exp_q.push_back({24'h0, w ? req1_data : req0_data});
                    src_q.push_back(w);
                    accept_log.push_back(int'(w));
                    model_last = w;
                    inflight = 1;
                    awaiting = 1;
                    acc_cyc = cyc;
                    if (w && q1.size() > 0) void'(q1.pop_front());
                    if (!w && q0.size() > 0) void'(q0.pop_front());
                end
            end

            if (done || done_due) begin
                chk("done_pulse", 32'(done), 32'(done_due));
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                    chk("done_expected", 32'(src_q.size() > 0), 32'd1);
                    if (src_q.size() > 0) chk("last_src", 32'(last_src), 32'(src_q.pop_front()));
                    inflight = 0;
                end
            end
            done_due = pd;
        end
    end

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while ((inflight || q0.size() > 0 || q1.size() > 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_idle_reached"}, 32'(n < max), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ready"}, {req0_ready, req1_ready}, 32'd0);
        chk({name, "_bus"}, {bus_req, rd, wr, done}, 32'd0);
        chk({name, "_addr"}, addr, 32'd0);
        chk({name, "_wdata"}, wdata, 32'd0);
        chk({name, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int d0, w0, n, alen;
        reset = 1'b0; err_clr = 1'b0; bus_gnt = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22;
        #12;
        check_all_zero("reset");
        chk("reset_flags", {last_src, timeout_err}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #3 reset = 1'b1;

        // Contention: both streams held valid, strict alternation from req0.
        gnt_mode = 0; p0 = 100; p1 = 100;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'($urandom));
            q1.push_back(8'($urandom));
        end
        accept_log.delete();
        w0 = wr_count; d0 = done_count;
        drv_en = 1;
        wait_idle(3000, "contention");
        chk("contention_accepts", 32'(accept_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < accept_log.size(); i++)
            chk("contention_order", 32'(accept_log[i]), 32'(i % 2));
        chk("contention_wr_count", 32'(wr_count - w0), 32'd8);
        chk("contention_done_count", 32'(done_count - d0), 32'd8);

        // Single byte, busy for 30 cycles after the write.
        gnt_mode = 1; busy_fixed = 30;
        q0.push_back(8'hA5);
        wait_idle(500, "single");
        chk("single_acc_to_wr", 32'(wr_cyc - acc_cyc), 32'd1);
        chk("single_wr_to_done", 32'(done_cyc - wr_cyc), 32'd31);
        chk("single_last_src", 32'(last_src), 32'd0);

        // Transmitter already idle at first poll: minimum wr-to-done latency.
        busy_fixed = 0;
        q1.push_back(8'h3C);
        wait_idle(500, "min_latency");
        chk("min_wr_to_done", 32'(done_cyc - wr_cyc), 32'(SETTLE + 2));
        chk("min_last_src", 32'(last_src), 32'd1);

        // Random traffic with gaps, random grants and busy lengths.
        busy_fixed = -1; gnt_mode = 0; p0 = 60; p1 = 60;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(8'($urandom));
            else q1.push_back(8'($urandom));
        end
        wait_idle(20000, "random");

        // Grant stall longer than the timeout: no error, write on first grant.
        gnt_mode = 2; busy_fixed = 5;
        q1.push_back(8'($urandom));
        n = 0;
        while (!awaiting && n < 50) begin @(posedge clk); n++; end
        chk("stall_reached_write", 32'(awaiting), 32'd1);
        w0 = wr_count;
        repeat (TMO + 10) @(posedge clk);
        chk("stall_no_timeout", 32'(timeout_err), 32'd0);
        chk("stall_no_wr", 32'(wr_count - w0), 32'd0);
        gnt_mode = 1;
        wait_idle(500, "stall");
        chk("stall_wr_after_gnt", 32'(wr_count - w0), 32'd1);

        // Transmitter stuck busy: timeout, no done, byte dropped.
        stuck = 1; gnt_mode = 0; busy_fixed = 0;
        d0 = done_count;
        q0.push_back(8'($urandom));
        n = 0;
        while (!timeout_err && n < 300) begin @(negedge clk); n++; end
        @(posedge clk);
        chk("stuck_timeout_set", 32'(timeout_err), 32'd1);
        chk("stuck_timeout_latency", 32'(err_cyc - wr_cyc), 32'(TMO));
        chk("stuck_no_done", 32'(done_count - d0), 32'd0);
        stuck = 0; busy_fixed = 3;
        q1.push_back(8'($urandom));
        wait_idle(500, "after_timeout");
        chk("timeout_sticky", 32'(timeout_err), 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(negedge clk);
        chk("err_clr_before_edge", 32'(timeout_err), 32'd1);
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_cleared", 32'(timeout_err), 32'd0);

        // Reset asserted while polling; req0 must win first afterwards.
        gnt_mode = 1; busy_fixed = 30;
        q0.push_back(8'($urandom));
        n = 0;
        while (!rd && n < 200) begin @(negedge clk); n++; end
        chk("reset_test_reached_poll", 32'(rd), 32'd1);
        q0.push_back(8'($urandom));
        q1.push_back(8'($urandom));
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        alen = accept_log.size();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        wait_idle(1000, "after_reset");
        chk("after_reset_accepts", 32'(accept_log.size() - alen), 32'd2);
        if (accept_log.size() >= alen + 2) begin
            chk("after_reset_first", 32'(accept_log[alen]), 32'd0);
            chk("after_reset_second", 32'(accept_log[alen + 1]), 32'd1);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("src_queue_empty", 32'(src_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
